demux8_dispatch: RTL
====================

# demux8_dispatch

Registered 1-to-8 demultiplexer with valid/ready handshakes. It accepts a 32-bit word tagged with a 3-bit destination select and delivers it, in order, to exactly one of eight consumer channels. It is the distribution counterpart of the datapath 8:1 selectors: results leave the core datapath through this block toward writeback, CSR, memory-store and peripheral consumers. An input FIFO decouples the producer from consumer back-pressure.

## Interface
- WIDTH, 32: data word width.
- DEPTH, 2: input FIFO depth in entries; must be a power of two, at least 2.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  producer has a word.
- IN_READY  out  1  block can accept a word this cycle.
- IN_SEL  in  3  destination channel, 0..7.
- IN_DATA  in  WIDTH  word to route.
- OUT_VALID  out  8  one-hot: bit i set means channel i has a word.
- OUT_READY  in  8  per-channel consumer ready.
- OUT_DATA  out  WIDTH  shared output data bus; valid for the channel flagged in OUT_VALID.
- COUNT  out  $clog2(DEPTH+1)+1  words held: FIFO entries plus the output stage.

## Operation
- Input accept: a word is accepted when IN_VALID && IN_READY at the clock edge. It is pushed as {IN_SEL, IN_DATA} into the FIFO.
- IN_READY = (FIFO occupancy < DEPTH), driven from registered state only. It has no combinational path from OUT_READY.
- Output stage FSM with two states:
  - EMPTY: OUT_VALID = 0. If the FIFO is non-empty, pop the head into the output register and go to HOLD.
  - HOLD: OUT_VALID = 1 << sel_reg and OUT_DATA = data_reg.
    - If OUT_READY[sel_reg] is high, the transfer completes. If the FIFO is non-empty, pop the head into the output register and stay in HOLD (back-to-back). Otherwise go to EMPTY.
    - If OUT_READY[sel_reg] is low, hold. OUT_DATA and OUT_VALID stay stable.
- Only OUT_READY[sel_reg] is observed. Ready bits of other channels are ignored.
- Strict in-order delivery. Head-of-line blocking across channels is intended: a stalled channel blocks later words bound for other channels.
- Simultaneous push and pop in the same cycle: FIFO occupancy is unchanged and both operations take effect.
  - When the FIFO is full, IN_READY is already low, so no push occurs even if a pop happens that cycle. IN_READY rises the following cycle.
- A word with IN_VALID high and IN_READY low is not accepted. The producer must hold it, and the block does not sample it.
- COUNT = FIFO occupancy + (state == HOLD). It updates on the same edge as the push or pop.
- FIFO pointers wrap modulo DEPTH. Occupancy is tracked with one extra bit so that full and empty are distinguishable.

## Timing
- Reset, synchronous: while RST is high at an edge, all of the following take effect at that edge:
  - FIFO is emptied and pointers are set to 0.
  - FSM goes to EMPTY.
  - OUT_VALID = 0, OUT_DATA = 0, COUNT = 0.
  - IN_READY = 0 while RST is high. IN_READY = 1 in the first cycle after RST falls.
- Reset mid-operation: any word in the FIFO or the output stage is discarded. No OUT_VALID pulse follows the reset edge.
- Latency: a word accepted at edge N, with the block idle, is pushed at edge N and popped to the output stage at edge N+1. OUT_VALID is visible from edge N+1, so latency is 1 cycle after accept and 2 edges from the presentation edge.
- Throughput: one word per cycle when the destination ready bits are held high.
- The handshake follows AXI-stream rules. OUT_VALID must not drop, and OUT_DATA must not change, until the transfer completes.

## Test plan
- Reset then single word: IN_SEL=5, IN_DATA=0xDEADBEEF. Required: OUT_VALID=8'b0010_0000 and OUT_DATA=0xDEADBEEF one cycle after accept. With OUT_READY[5]=1, the next cycle shows OUT_VALID=0 and COUNT=0.
- Streaming: sel 0..7 with data 0x10..0x17 on consecutive cycles, OUT_READY=8'hFF. Required: eight consecutive cycles with one-hot OUT_VALID walking bit 0 to bit 7 and matching data, and IN_READY never low.
- Back-pressure: target channel 3 with OUT_READY[3]=0, all other ready bits set to 1, push 4 words. Required: after 3 accepts, IN_READY=0 and COUNT=3 (DEPTH=2). Output stays stable on channel 3. Releasing OUT_READY[3] drains the words in order, and IN_READY rises one cycle after the first pop.
- Head-of-line: word A to channel 2 (not ready), then word B to channel 6 (ready). Required: B is not presented until A completes, and OUT_VALID never has two bits set.
- Full with simultaneous pop: with the FIFO full and IN_VALID held high, complete an output transfer. Required: no push on that edge, and the push succeeds on the next edge. The scoreboard sees no loss or duplication.
- Reset mid-stream: assert RST while COUNT=3. Required: OUT_VALID=0, OUT_DATA=0 and COUNT=0 after the edge, and no stale word is delivered after RST falls.

Source files
------------

// File: rtl/demux8_dispatch.sv
// -----------------------------------------------------------------------------
// demux8_dispatch
//
// Registered 1-to-8 demultiplexer with valid/ready handshakes. Words tagged
// with a 3-bit destination pass through a small input FIFO and a single output
// register. Each word is delivered, strictly in order, to exactly one of eight
// consumer channels. A stalled channel blocks every later word (head-of-line
// blocking is intentional).
//
// Parameters
//   WIDTH      data word width
//   DEPTH      input FIFO depth in entries (power of two, >= 2)
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   IN_VALID   producer has a word
//   IN_READY   block can accept a word this cycle
//   IN_SEL     destination channel 0..7
//   IN_DATA    word to route
//   OUT_VALID  one-hot, bit i = channel i has a word
//   OUT_READY  per-channel consumer ready
//   OUT_DATA   shared output bus, valid for the flagged channel
//   COUNT      words held: FIFO occupancy plus the output stage
// -----------------------------------------------------------------------------
module demux8_dispatch #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [2:0]                 IN_SEL,
  input  logic [WIDTH-1:0]           IN_DATA,
  output logic [7:0]                 OUT_VALID,
  input  logic [7:0]                 OUT_READY,
  output logic [WIDTH-1:0]           OUT_DATA,
  output logic [$clog2(DEPTH+1):0]   COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam int EW = WIDTH + 3;
  localparam logic [AW:0] DEPTH_OCC = (AW + 1)'(DEPTH);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // FIFO storage: each entry is {sel, data}
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   occ_reg;

  // Output stage
  state_t         state_reg;
  logic [2:0]     sel_reg;
  logic [WIDTH-1:0] data_reg;
  logic [7:0]     out_valid_reg;

  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign fifo_empty = (occ_reg == '0);
  assign head       = mem[rd_ptr_reg];

  // Ready depends only on the occupancy register and reset, never on
  // OUT_READY, so the producer sees no combinational path from consumers.
  // Gating with RST keeps the input closed during reset and opens it in the
  // first cycle after reset is released.
  assign IN_READY = !RST && (occ_reg < DEPTH_OCC);
  assign push     = IN_VALID && IN_READY;

  // The output register takes the FIFO head when it is empty, or when the
  // word it holds is consumed this cycle (back-to-back transfer).
  assign pop = !fifo_empty &&
               ((state_reg == ST_EMPTY) || OUT_READY[sel_reg]);

  // FIFO write port; contents need no reset because occupancy guards reads
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= {IN_SEL, IN_DATA};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Output-stage FSM with registered valid/data
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_EMPTY;
      sel_reg       <= '0;
      data_reg      <= '0;
      out_valid_reg <= '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (pop) begin
            sel_reg       <= head[EW-1:WIDTH];
            data_reg      <= head[WIDTH-1:0];
            out_valid_reg <= 8'd1 << head[EW-1:WIDTH];
            state_reg     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (OUT_READY[sel_reg]) begin
            if (pop) begin
              sel_reg       <= head[EW-1:WIDTH];
              data_reg      <= head[WIDTH-1:0];
              out_valid_reg <= 8'd1 << head[EW-1:WIDTH];
            end else begin
              // data_reg is left as is; it is only meaningful with valid set
              out_valid_reg <= '0;
              state_reg     <= ST_EMPTY;
            end
          end
        end
        default: begin
          state_reg     <= ST_EMPTY;
          out_valid_reg <= '0;
        end
      endcase
    end
  end

  assign OUT_VALID = out_valid_reg;
  assign OUT_DATA  = data_reg;
  assign COUNT     = CW'(occ_reg) + CW'(state_reg == ST_HOLD);

endmodule
